// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI gateway: directory descriptor layout,
// per-entry lifecycle state, completion codes and directory error causes.
package apb2axi_pkg;

    // Default directory size.
    localparam int DIR_ENTRIES = 16;

    // Width of the tag field inside a stored descriptor. It is wide enough for
    // directories up to 256 entries; smaller directories zero-extend the tag.
    localparam int DIR_TAG_W = 8;

    // Completion codes held in the descriptor's own .state field.
    localparam logic [1:0] DIR_ST_NONE  = 2'd0;
    localparam logic [1:0] DIR_ST_DONE  = 2'd1;
    localparam logic [1:0] DIR_ST_ERROR = 2'd2;

    // Lifecycle of one directory slot.
    typedef enum logic [1:0] {
        ENTRY_EMPTY     = 2'd0,
        ENTRY_ALLOCATED = 2'd1,
        ENTRY_PENDING   = 2'd2,
        ENTRY_COMPLETE  = 2'd3
    } entry_state_e;

    // Cause of the most recent rejected completion or consume.
    typedef enum logic [1:0] {
        ERR_NONE                 = 2'd0,
        ERR_CPL_NOT_PENDING      = 2'd1,
        ERR_CONSUME_NOT_COMPLETE = 2'd2
    } dir_err_e;

    // One APB-originated AXI descriptor plus its completion result.
    typedef struct packed {
        logic                 is_write;
        logic [31:0]          addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [DIR_TAG_W-1:0] tag;
        logic [1:0]           resp;
        logic [7:0]           num_beats;
        logic [1:0]           state;
    } directory_entry_t;

endpackage

// File: rtl/apb2axi_tag_fifo.sv
// Age FIFO of directory tags. Tags leave in the order they were allocated.
// The pointers carry one extra wrap bit so full and empty are distinguishable.
module apb2axi_tag_fifo
    import apb2axi_pkg::*;
#(
    parameter int DEPTH_P = DIR_ENTRIES,
    parameter int W_P     = $clog2(DIR_ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [W_P-1:0] push_data,
    input  logic           pop,
    output logic [W_P-1:0] head,
    output logic           empty,
    output logic           full
);

    localparam int PTR_W = $clog2(DEPTH_P);

    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic [W_P-1:0] mem_q [DEPTH_P];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Advance the pointers; the callers never push when full or pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Tag storage; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/apb2axi_tag_directory.sv
// Tag directory between the APB register front-end and the AXI transaction
// manager. Each slot walks EMPTY -> ALLOCATED -> PENDING -> COMPLETE -> EMPTY.
// Allocation takes the lowest free slot, issue follows allocation age, and the
// number of PENDING slots is capped.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on valid, and pop_valid/pop_tag stay stable until
// pop_ready. All same-cycle events act on the state as it was before the edge.
module apb2axi_tag_directory
    import apb2axi_pkg::*;
#(
    parameter int DIR_ENTRIES_P     = DIR_ENTRIES,
    parameter int TAG_W_P           = $clog2(DIR_ENTRIES_P),
    parameter int MAX_OUTSTANDING_P = DIR_ENTRIES_P
) (
    input  logic               pclk,
    input  logic               presetn,
    // allocate
    input  logic               alloc_valid,
    input  directory_entry_t   alloc_entry,
    output logic               alloc_ready,
    output logic [TAG_W_P-1:0] alloc_tag,
    // pop
    output logic               pop_valid,
    output directory_entry_t   pop_entry,
    output logic [TAG_W_P-1:0] pop_tag,
    input  logic               pop_ready,
    // complete
    input  logic               cpl_valid,
    input  logic [TAG_W_P-1:0] cpl_tag,
    input  logic               cpl_error,
    input  logic [1:0]         cpl_resp,
    input  logic [7:0]         cpl_num_beats,
    output logic               cpl_ready,
    // consume
    input  logic               consume_valid,
    input  logic [TAG_W_P-1:0] consume_tag,
    // status
    input  logic [TAG_W_P-1:0] status_tag_sel,
    output directory_entry_t   status_entry,
    output entry_state_e       status_state,
    // counters and error
    output logic [TAG_W_P:0]   occupancy,
    output logic [TAG_W_P:0]   pending_cnt,
    output logic               proto_err,
    output dir_err_e           proto_err_code
);

    entry_state_e     state_q [DIR_ENTRIES_P];
    directory_entry_t entry_q [DIR_ENTRIES_P];

    logic [TAG_W_P:0] occupancy_q;
    logic [TAG_W_P:0] pending_q;
    logic             cpl_ready_q;
    logic             proto_err_q;
    dir_err_e         proto_err_code_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             alloc_fire;
    logic             pop_fire;
    logic             cpl_hit;
    logic             cpl_bad;
    logic             consume_hit;
    logic             consume_bad;
    directory_entry_t alloc_entry_fmt;

    // Lowest EMPTY index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        alloc_tag = '0;
        for (int i = DIR_ENTRIES_P - 1; i >= 0; i--) begin
            if (state_q[i] == ENTRY_EMPTY) alloc_tag = TAG_W_P'(i);
        end
    end

    assign alloc_ready = (occupancy_q != (TAG_W_P + 1)'(DIR_ENTRIES_P));
    assign pop_valid   = !fifo_empty && (pending_q < (TAG_W_P + 1)'(MAX_OUTSTANDING_P));
    assign pop_entry   = entry_q[pop_tag];

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign pop_fire    = pop_valid && pop_ready;
    assign cpl_hit     = cpl_valid && (state_q[cpl_tag] == ENTRY_PENDING);
    assign cpl_bad     = cpl_valid && (state_q[cpl_tag] != ENTRY_PENDING);
    assign consume_hit = consume_valid && (state_q[consume_tag] == ENTRY_COMPLETE);
    assign consume_bad = consume_valid && (state_q[consume_tag] != ENTRY_COMPLETE);

    assign cpl_ready      = cpl_ready_q;
    assign status_entry   = entry_q[status_tag_sel];
    assign status_state   = state_q[status_tag_sel];
    assign occupancy      = occupancy_q;
    assign pending_cnt    = pending_q;
    assign proto_err      = proto_err_q;
    assign proto_err_code = proto_err_code_q;

    // Descriptor as stored: tag forced to its slot, result fields cleared.
    always_comb begin
        alloc_entry_fmt           = alloc_entry;
        alloc_entry_fmt.tag       = DIR_TAG_W'(alloc_tag);
        alloc_entry_fmt.resp      = '0;
        alloc_entry_fmt.num_beats = '0;
        alloc_entry_fmt.state     = DIR_ST_NONE;
    end

    apb2axi_tag_fifo #(
        .DEPTH_P (DIR_ENTRIES_P),
        .W_P     (TAG_W_P)
    ) u_age_fifo (
        .clk       (pclk),
        .rst_n     (presetn),
        .push      (alloc_fire && !fifo_full),
        .push_data (alloc_tag),
        .pop       (pop_fire),
        .head      (pop_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Slot state and storage. Each event targets a slot in a different state,
    // so at most one event ever writes a given slot in one cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DIR_ENTRIES_P; i++) begin
                state_q[i] <= ENTRY_EMPTY;
                entry_q[i] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                state_q[alloc_tag] <= ENTRY_ALLOCATED;
                entry_q[alloc_tag] <= alloc_entry_fmt;
            end
            if (pop_fire) begin
                state_q[pop_tag] <= ENTRY_PENDING;
            end
            if (cpl_hit) begin
                state_q[cpl_tag]           <= ENTRY_COMPLETE;
                entry_q[cpl_tag].resp      <= cpl_resp;
                entry_q[cpl_tag].num_beats <= cpl_num_beats;
                entry_q[cpl_tag].state     <= cpl_error ? DIR_ST_ERROR : DIR_ST_DONE;
            end
            if (consume_hit) begin
                state_q[consume_tag] <= ENTRY_EMPTY;
                entry_q[consume_tag] <= '0;
            end
        end
    end

    // Occupancy and in-flight counters; a simultaneous +1 and -1 cancel.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            occupancy_q <= '0;
            pending_q   <= '0;
        end else begin
            occupancy_q <= occupancy_q + (TAG_W_P + 1)'(alloc_fire)
                                       - (TAG_W_P + 1)'(consume_hit);
            pending_q   <= pending_q + (TAG_W_P + 1)'(pop_fire)
                                     - (TAG_W_P + 1)'(cpl_hit);
        end
    end

    // Completion ready rises once reset is released.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) cpl_ready_q <= 1'b0;
        else          cpl_ready_q <= 1'b1;
    end

    // Protocol error pulse; a bad completion outranks a bad consume.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            proto_err_q      <= 1'b0;
            proto_err_code_q <= ERR_NONE;
        end else begin
            proto_err_q <= cpl_bad || consume_bad;
            if (cpl_bad)          proto_err_code_q <= ERR_CPL_NOT_PENDING;
            else if (consume_bad) proto_err_code_q <= ERR_CONSUME_NOT_COMPLETE;
        end
    end

endmodule

// File: doc/apb2axi_tag_directory.md
# apb2axi_tag_directory

Parametrised successor to the gateway transaction directory: tracks up to `DIR_ENTRIES_P` APB-originated AXI descriptors through EMPTY → ALLOCATED → PENDING → COMPLETE → EMPTY. It allocates the lowest free slot instead of a round-robin pointer, issues descriptors to the transaction manager in allocation order, and caps in-flight AXI transactions. It detects protocol misuse on completion and consume, and exports occupancy counters. It sits between the APB register front-end and the AXI transaction manager.

## Interface
Parameters:
- `DIR_ENTRIES_P`, default 16: number of entries; a power of two, at least 2.
- `TAG_W_P`, default `$clog2(DIR_ENTRIES_P)`: tag width.
- `MAX_OUTSTANDING_P`, default `DIR_ENTRIES_P`: maximum number of entries in PENDING; range 1..`DIR_ENTRIES_P`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `pclk` in 1: clock.
  - `presetn` in 1: reset.
- Allocate:
  - `alloc_valid` in 1: new descriptor offered.
  - `alloc_entry` in `directory_entry_t`: the descriptor.
  - `alloc_ready` out 1: a free entry exists.
  - `alloc_tag` out `TAG_W_P`: tag that this cycle's accepted descriptor receives.
- Pop:
  - `pop_valid` out 1: an ALLOCATED entry is issuable.
  - `pop_entry` out `directory_entry_t`: oldest ALLOCATED entry.
  - `pop_tag` out `TAG_W_P`: its tag.
  - `pop_ready` in 1: transaction manager accepts.
- Complete:
  - `cpl_valid` in 1: completion report.
  - `cpl_tag` in `TAG_W_P`: completed tag.
  - `cpl_error` in 1: the transaction failed.
  - `cpl_resp` in 2: AXI response.
  - `cpl_num_beats` in 8: number of beats transferred.
  - `cpl_ready` out 1: completion accepted.
- Consume:
  - `consume_valid` in 1: APB has read the result.
  - `consume_tag` in `TAG_W_P`: the tag to release.
- Status:
  - `status_tag_sel` in `TAG_W_P`: tag to inspect.
  - `status_entry` out `directory_entry_t`: stored descriptor for that tag.
  - `status_state` out `entry_state_e`: state of that tag.
- Counters and error:
  - `occupancy` out `TAG_W_P+1`: number of non-EMPTY entries.
  - `pending_cnt` out `TAG_W_P+1`: number of PENDING entries.
  - `proto_err` out 1: one-cycle pulse on a rejected completion or consume.
  - `proto_err_code` out `dir_err_e`: cause of the last `proto_err`.

## Operation
- **Allocate.** `alloc_tag` is the lowest index whose state is EMPTY (priority encoder). `alloc_ready` = (`occupancy` != `DIR_ENTRIES_P`). On `alloc_valid && alloc_ready`:
  - the entry stores `alloc_entry`, with `.tag` forced to `alloc_tag`, and `.resp`, `.num_beats` and `.state` cleared;
  - the entry state becomes ALLOCATED;
  - the tag is pushed into the age FIFO.
- **Pop.**
  - `pop_valid` = (age FIFO not empty) && (`pending_cnt` < `MAX_OUTSTANDING_P`).
  - `pop_tag` is the FIFO head; `pop_entry` = `entry[pop_tag]`.
  - On handshake the head is dequeued and the entry state becomes PENDING.
  - Issue order is strict allocation order, regardless of index.
- **Complete.** `cpl_ready` is constantly 1 out of reset. On `cpl_valid`:
  - Tag in PENDING: state becomes COMPLETE; store `resp` and `num_beats`; `.state` = `DIR_ST_ERROR` if `cpl_error`, otherwise `DIR_ST_DONE`.
  - Tag not in PENDING: ignored, with `proto_err` = 1 and `proto_err_code` = `ERR_CPL_NOT_PENDING`.
- **Consume.** On `consume_valid`:
  - Tag in COMPLETE: state becomes EMPTY and the entry is cleared to `'0`.
  - Otherwise: ignored, with `ERR_CONSUME_NOT_COMPLETE`.
  - If both errors occur in the same cycle, `ERR_CPL_NOT_PENDING` is reported.
- **Counters** update in the same edge as the state changes:
  - `occupancy`: +1 on alloc, −1 on a valid consume.
  - `pending_cnt`: +1 on pop, −1 on a valid completion.
  - Simultaneous +1 and −1 leaves the counter unchanged.
- **Same-cycle events** all act on the registered state as it was before the edge:
  - Pop and completion of the same tag: the completion sees ALLOCATED and is rejected.
  - A consume frees its slot for allocation only from the next cycle.
  - A completion and a pop decrementing and incrementing `pending_cnt` together are both honoured.
- **Age FIFO** has depth `DIR_ENTRIES_P`, so it never overflows. Its pointers are `TAG_W_P` bits and wrap modulo `DIR_ENTRIES_P`, with an extra wrap bit for full/empty detection.

## Timing
- Outputs that are combinational from registered state: `alloc_ready`, `alloc_tag`, `pop_valid`, `pop_tag`, `pop_entry`, `status_entry`, `status_state`.
- Latency: alloc → `pop_valid` is 1 cycle when the FIFO was empty. Completion → `status_state` shows COMPLETE 1 cycle later.
- `proto_err` and `proto_err_code` are registered and assert the cycle after the offending input.
- Handshakes: `pop_valid` and `pop_tag` stay stable until `pop_ready`. `alloc_ready` never depends on `alloc_valid`.
- Reset (asynchronous assert):
  - All entries EMPTY and all entries `'0`; FIFO empty; counters 0.
  - `alloc_ready` = 1, `alloc_tag` = 0, `pop_valid` = 0, `cpl_ready` = 0 while reset is held and 1 after deassertion.
  - `proto_err` = 0, `proto_err_code` = `ERR_NONE`.
  - Reset asserted mid-operation discards all in-flight state with no completion reported.

## Structure
- `apb2axi_pkg` holds `directory_entry_t`, `entry_state_e`, the `DIR_ST_*` codes, the new enum `dir_err_e {ERR_NONE, ERR_CPL_NOT_PENDING, ERR_CONSUME_NOT_COMPLETE}`, and a default `DIR_ENTRIES`.
- One sub-module, `apb2axi_tag_fifo` (parameters: `DEPTH_P`, `W_P`), implements the age FIFO. The free-slot encoder, state array and counters stay in the top module.

## Test plan
- **Fill and full:** 16 allocations with no pops → tags 0..15, `occupancy` = 16, `alloc_ready` = 0. One more `alloc_valid` is not accepted.
- **Hole reuse and age order:**
  - Allocate 0..3, then pop, complete and consume tag 1, then allocate → new tag = 1.
  - Pop order is 2, 3, 1 (allocation order), not index order.
- **Outstanding cap** with `MAX_OUTSTANDING_P` = 2: allocate 4 and hold `pop_ready` = 1 → 2 pops, then `pop_valid` = 0. One completion → `pop_valid` = 1 the next cycle.
- **Protocol errors:**
  - Completion for an ALLOCATED tag → `proto_err` pulse with `ERR_CPL_NOT_PENDING`, state unchanged.
  - Consume of a PENDING tag → `ERR_CONSUME_NOT_COMPLETE`.
- **Error completion:** `cpl_error` = 1, `resp` = 2'b10, `num_beats` = 4 → `status_entry.state` = `DIR_ST_ERROR`, `resp` = 2, `num_beats` = 4.
- **Mid-operation reset:** assert `presetn` = 0 with 3 PENDING entries → all outputs at their reset values immediately (asynchronously). After release, the first allocation gets tag 0.
